// File: rtl/lms_rst_seq.sv
// Power-up/reset sequencer for the LMS7002 transceiver: drives the core LDO enable and the
// hardware reset line through a timed LDO_ON -> RST_HOLD -> SETTLE -> DONE sequence.
module lms_rst_seq #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned LDO_WAIT_CYCLES = 5000,
   parameter int unsigned RST_CYCLES      = 1000,
   parameter int unsigned SETTLE_CYCLES   = 2000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_in,
   output logic       lms_ldo_en,
   output logic       lms_rst_n,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic [7:0] seq_cnt
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LDO_ON   = 3'd1;
   localparam logic [2:0] S_RST_HOLD = 3'd2;
   localparam logic [2:0] S_SETTLE   = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [CNT_W-1:0] LDO_LOAD    = CNT_W'(LDO_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_req_s;

   logic [2:0]       r_state;
   logic [2:0]       w_state_d;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_aborted;
   logic             w_aborted_d;
   logic [7:0]       r_seq_cnt;
   logic [7:0]       w_seq_cnt_d;

   // req_in comes from another clock domain's PIO; only the last stage is used.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
      end
   end

   assign w_req_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt - CNT_W'(1);
      w_aborted_d = r_aborted;
      w_seq_cnt_d = r_seq_cnt;

      case (r_state)
         S_IDLE: begin
            if (w_req_s) begin
               w_state_d   = S_LDO_ON;
               w_cnt_d     = LDO_LOAD;
               w_aborted_d = 1'b0;
            end
         end
         S_LDO_ON: begin
            if (!w_req_s) begin
               w_state_d   = S_IDLE;
               w_aborted_d = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_d = S_RST_HOLD;
               w_cnt_d   = RST_LOAD;
            end
         end
         S_RST_HOLD: begin
            if (!w_req_s) begin
               w_state_d   = S_IDLE;
               w_aborted_d = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_d = S_SETTLE;
               w_cnt_d   = SETTLE_LOAD;
            end
         end
         S_SETTLE: begin
            if (!w_req_s) begin
               w_state_d   = S_IDLE;
               w_aborted_d = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_d   = S_DONE;
               w_seq_cnt_d = r_seq_cnt + 8'd1;
            end
         end
         S_DONE: begin
            // A normal release after completion is not an abort.
            if (!w_req_s) begin
               w_state_d = S_IDLE;
            end
         end
         default: begin
            w_state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_aborted <= 1'b0;
         r_seq_cnt <= 8'd0;
      end else begin
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_aborted <= w_aborted_d;
         r_seq_cnt <= w_seq_cnt_d;
      end
   end

   // Outputs come straight off the state register so an async reset is seen at once.
   always_comb begin
      lms_ldo_en = 1'b0;
      lms_rst_n  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_LDO_ON, S_RST_HOLD: begin
            lms_ldo_en = 1'b1;
            busy       = 1'b1;
         end
         S_SETTLE: begin
            lms_ldo_en = 1'b1;
            lms_rst_n  = 1'b1;
            busy       = 1'b1;
         end
         S_DONE: begin
            lms_ldo_en = 1'b1;
            lms_rst_n  = 1'b1;
            done       = 1'b1;
         end
         default: begin
            lms_ldo_en = 1'b0;
         end
      endcase
   end

   assign aborted = r_aborted;
   assign seq_cnt = r_seq_cnt;

endmodule

// File: tb/tb_lms_rst_seq.sv
// Directed bench for lms_rst_seq with short phases (sync 2, LDO 4, RST 3, SETTLE 5).
module tb_lms_rst_seq;

   logic       clk;
   logic       reset_n;
   logic       req_in;
   logic       lms_ldo_en;
   logic       lms_rst_n;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [7:0] seq_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cycles;
   logic [7:0] exp_cnt;

   lms_rst_seq #(
      .SYNC_STAGES    (2),
      .LDO_WAIT_CYCLES(4),
      .RST_CYCLES     (3),
      .SETTLE_CYCLES  (5),
      .CNT_W          (16)
   ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_in    (req_in),
      .lms_ldo_en(lms_ldo_en),
      .lms_rst_n (lms_rst_n),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .seq_cnt   (seq_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts from IDLE with a clean synchroniser; DONE is entered on the 15th edge.
   task automatic full_seq();
      req_in = 1'b1;
      step(15);
      chk("seq_done", 32'(done), 32'd1);
      exp_cnt = exp_cnt + 8'd1;
      chk("seq_cnt", 32'(seq_cnt), 32'(exp_cnt));
      req_in = 1'b0;
      step(3);
   endtask

   initial begin
      reset_n = 1'b0;
      req_in  = 1'b0;
      exp_cnt = 8'd0;
      #12;
      chk("rst_ldo", 32'(lms_ldo_en), 32'd0);
      chk("rst_rstn", 32'(lms_rst_n), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_aborted", 32'(aborted), 32'd0);
      chk("rst_seq_cnt", 32'(seq_cnt), 32'd0);
      reset_n = 1'b1;

      // Full sequence, req_in high ahead of edge 1
      req_in = 1'b1;
      step(2);
      chk("t1_ldo_e2", 32'(lms_ldo_en), 32'd0);
      step(1);
      chk("t1_ldo_e3", 32'(lms_ldo_en), 32'd1);
      chk("t1_busy_e3", 32'(busy), 32'd1);
      chk("t1_rstn_e3", 32'(lms_rst_n), 32'd0);
      step(6);
      chk("t1_rstn_e9", 32'(lms_rst_n), 32'd0);
      step(1);
      chk("t1_rstn_e10", 32'(lms_rst_n), 32'd1);
      step(4);
      chk("t1_done_e14", 32'(done), 32'd0);
      chk("t1_busy_e14", 32'(busy), 32'd1);
      step(1);
      chk("t1_done_e15", 32'(done), 32'd1);
      chk("t1_busy_e15", 32'(busy), 32'd0);
      chk("t1_cnt_e15", 32'(seq_cnt), 32'd1);
      chk("t1_aborted", 32'(aborted), 32'd0);
      exp_cnt = 8'd1;

      // Hold in DONE, then release
      step(100);
      chk("t3_done_hold", 32'(done), 32'd1);
      chk("t3_cnt_hold", 32'(seq_cnt), 32'd1);
      req_in = 1'b0;
      step(2);
      chk("t3_done_lag", 32'(done), 32'd1);
      step(1);
      chk("t3_done_rel", 32'(done), 32'd0);
      chk("t3_ldo_rel", 32'(lms_ldo_en), 32'd0);
      chk("t3_rstn_rel", 32'(lms_rst_n), 32'd0);
      chk("t3_aborted", 32'(aborted), 32'd0);

      // Abort in RST_HOLD; drop lands on the edge where the counter also expires
      req_in = 1'b1;
      step(7);
      chk("t2_in_rsthold", 32'(busy), 32'd1);
      chk("t2_rstn_hold", 32'(lms_rst_n), 32'd0);
      req_in = 1'b0;
      step(2);
      chk("t2_busy_lag", 32'(busy), 32'd1);
      step(1);
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_ldo", 32'(lms_ldo_en), 32'd0);
      chk("t2_rstn", 32'(lms_rst_n), 32'd0);
      chk("t2_aborted", 32'(aborted), 32'd1);
      chk("t2_cnt", 32'(seq_cnt), 32'd1);
      req_in = 1'b1;
      step(2);
      chk("t2_abort_sticky", 32'(aborted), 32'd1);
      step(1);
      chk("t2_abort_clr", 32'(aborted), 32'd0);
      step(12);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_cnt_after", 32'(seq_cnt), 32'd2);
      exp_cnt = 8'd2;
      req_in = 1'b0;
      step(3);

      // Wrap: 253 more sequences reach 255, one more wraps to 0
      for (int i = 0; i < 253; i++) full_seq();
      chk("t4_cnt_255", 32'(seq_cnt), 32'd255);
      full_seq();
      chk("t4_cnt_wrap", 32'(seq_cnt), 32'd0);
      full_seq();

      // One-cycle request pulse
      req_in = 1'b1;
      step(1);
      req_in = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (busy) busy_cycles++;
      end
      chk("t6_busy_cycles", 32'(busy_cycles), 32'd1);
      chk("t6_aborted", 32'(aborted), 32'd1);
      chk("t6_cnt", 32'(seq_cnt), 32'd1);

      // Async reset while in SETTLE
      req_in = 1'b1;
      step(11);
      chk("t5_in_settle", 32'(lms_rst_n), 32'd1);
      chk("t5_busy", 32'(busy), 32'd1);
      chk("t5_cnt_pre", 32'(seq_cnt), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_ldo", 32'(lms_ldo_en), 32'd0);
      chk("t5_rstn", 32'(lms_rst_n), 32'd0);
      chk("t5_busy_rst", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_aborted", 32'(aborted), 32'd0);
      chk("t5_cnt", 32'(seq_cnt), 32'd0);
      step(2);
      reset_n = 1'b1;
      req_in  = 1'b0;
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
